smul_seq: RTL and testbench

- Multi-cycle, parametrised multiplier; next generation of the combinational signed multiply component.
- Adds a run-time signed/unsigned mode, full double-width product and an overflow flag for truncation to DATAWIDTH.
- Valid/ready handshakes on input and output; iterative shift-add datapath, one partial product per cycle.
- Sits in generated datapaths where a wide combinational multiplier would break timing or area budgets.

---
 rtl/smul_seq_pkg.sv | 26 ++
 rtl/smul_negate.sv | 21 ++
 rtl/smul_seq.sv | 192 +++++++++++++++++++
 tb/tb_smul_seq.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/smul_seq_pkg.sv
// Shared definitions for the sequential arithmetic family (multiply now,
// divide/modulo later): FSM state encoding and iteration counter sizing.
package smul_defs;

    typedef enum logic [1:0] {
        SM_IDLE = 2'd0,
        SM_CALC = 2'd1,
        SM_FIX  = 2'd2,
        SM_DONE = 2'd3
    } sm_state_e;

    localparam int SM_MAX_WIDTH = 64;
    localparam int SM_CNT_W_MAX = $clog2(SM_MAX_WIDTH);

    // Counter width able to index iterations 0..width-1 (at least one bit).
    function automatic int sm_cnt_width(input int width);
        int w;
        if (width > 2) begin
            w = $clog2(width);
        end else begin
            w = 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/smul_negate.sv
// Conditional two's-complement: dout = en ? -din : din.
// Used for operand magnitudes at capture and for the final sign fix-up.
module smul_negate #(
    parameter int W = 8
) (
    input  logic [W-1:0] din,
    input  logic         en,
    output logic [W-1:0] dout
);

    // Invert-and-increment when enabled, pass through otherwise.
    always_comb begin
        dout = din;
        if (en) begin
            dout = ~din + W'(1);
        end else begin
            dout = din;
        end
    end

endmodule

// File: rtl/smul_seq.sv
// Iterative shift-add multiplier with run-time signed/unsigned mode,
// full double-width product, truncation overflow flag and valid/ready
// handshakes. Sign is handled by multiplying magnitudes and negating once.
module smul_seq
    import smul_defs::*;
#(
    parameter int DATAWIDTH = 64
) (
    input  logic                   Clk,
    input  logic                   Rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic                   is_signed,
    input  logic [DATAWIDTH-1:0]   a,
    input  logic [DATAWIDTH-1:0]   b,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [2*DATAWIDTH-1:0] prod,
    output logic                   ovf
);

    localparam int PW = 2 * DATAWIDTH;
    localparam int CW = sm_cnt_width(DATAWIDTH);
    localparam logic [CW-1:0] LAST_CNT = CW'(DATAWIDTH - 1);

    sm_state_e state_r;
    sm_state_e state_next_s;

    logic [DATAWIDTH-1:0] mcand_r;
    logic [DATAWIDTH-1:0] mplier_r;
    logic [DATAWIDTH-1:0] mag_a_s;
    logic [DATAWIDTH-1:0] mag_b_s;
    logic [PW-1:0]        acc_r;
    logic [PW-1:0]        addend_s;
    logic [PW-1:0]        prod_fix_s;
    logic [PW-1:0]        prod_r;
    logic [CW-1:0]        cnt_r;
    logic                 neg_r;
    logic                 sgn_r;
    logic                 ovf_r;
    logic                 in_ready_r;
    logic                 out_valid_r;
    logic                 in_ready_s;
    logic                 out_valid_s;
    logic                 accept_s;
    logic                 out_fire_s;

    // Product does not fit DATAWIDTH bits: signed needs the top N+1 bits
    // to be a pure sign extension, unsigned needs the upper half clear.
    function automatic logic calc_ovf(input logic [PW-1:0] p, input logic sgn);
        logic [DATAWIDTH:0] hi;
        logic               r;
        hi = p[PW-1:DATAWIDTH-1];
        if (sgn) begin
            r = !((&hi) || !(|hi));
        end else begin
            r = |p[PW-1:DATAWIDTH];
        end
        return r;
    endfunction

    assign accept_s   = (state_r == SM_IDLE) && in_valid && in_ready_r;
    assign out_fire_s = (state_r == SM_DONE) && out_valid_r && out_ready;
    assign addend_s   = {{DATAWIDTH{1'b0}}, mcand_r} << cnt_r;

    smul_negate #(.W(DATAWIDTH)) u_neg_a (
        .din  (a),
        .en   (is_signed & a[DATAWIDTH-1]),
        .dout (mag_a_s)
    );

    smul_negate #(.W(DATAWIDTH)) u_neg_b (
        .din  (b),
        .en   (is_signed & b[DATAWIDTH-1]),
        .dout (mag_b_s)
    );

    smul_negate #(.W(PW)) u_neg_p (
        .din  (acc_r),
        .en   (neg_r),
        .dout (prod_fix_s)
    );

    // FSM state register.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_r <= SM_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            SM_IDLE: begin
                if (accept_s) state_next_s = SM_CALC;
                else          state_next_s = SM_IDLE;
            end
            SM_CALC: begin
                if (cnt_r == LAST_CNT) state_next_s = SM_FIX;
                else                   state_next_s = SM_CALC;
            end
            SM_FIX:  state_next_s = SM_DONE;
            SM_DONE: begin
                if (out_fire_s) state_next_s = SM_IDLE;
                else            state_next_s = SM_DONE;
            end
            default: state_next_s = SM_IDLE;
        endcase
    end

    // FSM output decode; out_valid is raised one cycle into DONE so the
    // product has been stable for a full cycle before it is offered.
    always_comb begin
        in_ready_s  = 1'b0;
        out_valid_s = 1'b0;
        if (state_next_s == SM_IDLE) begin
            in_ready_s = 1'b1;
        end else begin
            in_ready_s = 1'b0;
        end
        if ((state_r == SM_DONE) && !out_fire_s) begin
            out_valid_s = 1'b1;
        end else begin
            out_valid_s = 1'b0;
        end
    end

    // Registered handshake outputs.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
        end else begin
            in_ready_r  <= in_ready_s;
            out_valid_r <= out_valid_s;
        end
    end

    // Datapath: capture magnitudes, one partial product per CALC cycle,
    // sign fix-up and overflow evaluation in FIX; result held otherwise.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            mcand_r  <= '0;
            mplier_r <= '0;
            acc_r    <= '0;
            cnt_r    <= '0;
            neg_r    <= 1'b0;
            sgn_r    <= 1'b0;
            prod_r   <= '0;
            ovf_r    <= 1'b0;
        end else begin
            case (state_r)
                SM_IDLE: begin
                    if (accept_s) begin
                        mcand_r  <= mag_a_s;
                        mplier_r <= mag_b_s;
                        neg_r    <= is_signed & (a[DATAWIDTH-1] ^ b[DATAWIDTH-1]);
                        sgn_r    <= is_signed;
                        acc_r    <= '0;
                        cnt_r    <= '0;
                    end
                end
                SM_CALC: begin
                    if (mplier_r[0]) begin
                        acc_r <= acc_r + addend_s;
                    end
                    mplier_r <= mplier_r >> 1;
                    cnt_r    <= cnt_r + CW'(1);
                end
                SM_FIX: begin
                    prod_r <= prod_fix_s;
                    ovf_r  <= calc_ovf(prod_fix_s, sgn_r);
                end
                SM_DONE: begin
                    prod_r <= prod_r;
                end
                default: begin
                    prod_r <= prod_r;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign prod      = prod_r;
    assign ovf       = ovf_r;

endmodule

// File: tb/tb_smul_seq.sv
// Self-checking bench for smul_seq: 8-bit directed vector table and
// multi-cycle corner sequences, plus random 8- and 64-bit operands checked
// against an arithmetic reference model.
module tb_smul_seq;

    logic clk;
    logic rst;

    logic         iv8, ir8, sg8, ov8, or8, f8;
    logic [7:0]   a8, b8;
    logic [15:0]  p8;
    logic         iv64, ir64, sg64, ov64, or64, f64;
    logic [63:0]  a64, b64;
    logic [127:0] p64;

    bit           sel64;
    logic         ir_v, ov_v, ovf_v;
    logic [127:0] prod_v;

    int checks;
    int failures;

    typedef struct {
        logic        sg;
        logic [7:0]  a;
        logic [7:0]  b;
        logic [15:0] p;
        logic        f;
    } vec_t;

    vec_t vt[10];

    smul_seq #(.DATAWIDTH(8)) dut8 (
        .Clk(clk), .Rst(rst), .in_valid(iv8), .in_ready(ir8), .is_signed(sg8),
        .a(a8), .b(b8), .out_valid(ov8), .out_ready(or8), .prod(p8), .ovf(f8)
    );

    smul_seq #(.DATAWIDTH(64)) dut64 (
        .Clk(clk), .Rst(rst), .in_valid(iv64), .in_ready(ir64), .is_signed(sg64),
        .a(a64), .b(b64), .out_valid(ov64), .out_ready(or64), .prod(p64), .ovf(f64)
    );

    assign ir_v   = sel64 ? ir64 : ir8;
    assign ov_v   = sel64 ? ov64 : ov8;
    assign ovf_v  = sel64 ? f64  : f8;
    assign prod_v = sel64 ? p64  : {112'd0, p8};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", nm, got, exp);
        end
    endtask

    // Reference: plain integer multiply of the operands interpreted per mode.
    task automatic model(input int n, input logic sg, input logic [63:0] a, input logic [63:0] b,
                         output logic [127:0] p, output logic f);
        logic [127:0]        ua, ub, up, mask;
        logic signed [127:0] sa, sb, sp, lim;
        ua   = {64'd0, a} & ((128'd1 << n) - 128'd1);
        ub   = {64'd0, b} & ((128'd1 << n) - 128'd1);
        mask = (128'd1 << (2 * n)) - 128'd1;
        if (sg) begin
            sa = ua;
            sb = ub;
            if (ua[n-1]) sa = sa - $signed(128'd1 << n);
            if (ub[n-1]) sb = sb - $signed(128'd1 << n);
            sp  = sa * sb;
            lim = $signed(128'd1 << (n - 1));
            p   = sp & mask;
            f   = (sp >= lim) || (sp < -lim);
        end else begin
            up = ua * ub;
            p  = up & mask;
            f  = (up >> n) != 128'd0;
        end
    endtask

    task automatic drive(input logic v, input logic sg, input logic [63:0] a, input logic [63:0] b);
        if (sel64) begin
            iv64 = v; sg64 = sg; a64 = a; b64 = b;
        end else begin
            iv8 = v; sg8 = sg; a8 = a[7:0]; b8 = b[7:0];
        end
    endtask

    task automatic set_ordy(input logic r);
        if (sel64) or64 = r;
        else       or8  = r;
    endtask

    // One transaction: accept, measure latency, check result, optional
    // backpressure hold and output/input handshake collision.
    task automatic run_op(input string nm, input logic sg, input logic [63:0] a, input logic [63:0] b,
                          input logic [127:0] ep, input logic ef, input bit hold, input bit collide);
        int n, lat, t;
        bit bad;
        n = sel64 ? 64 : 8;
        @(negedge clk);
        t = 0;
        while (!ir_v && t < 100) begin
            @(negedge clk);
            t++;
        end
        chk({nm, "/in_ready_idle"}, 128'(ir_v), 128'd1);
        drive(1'b1, sg, a, b);
        @(negedge clk);
        drive(1'b0, ~sg, ~a, ~b);
        lat = 0;
        bad = 1'b0;
        while (!ov_v && lat < 200) begin
            if (ir_v) bad = 1'b1;
            @(negedge clk);
            lat++;
        end
        chk({nm, "/latency"}, 128'(lat), 128'(n + 2));
        chk({nm, "/busy_in_ready"}, 128'(bad), 128'd0);
        chk({nm, "/prod"}, prod_v, ep);
        chk({nm, "/ovf"}, 128'(ovf_v), 128'(ef));
        if (hold) begin
            bad = 1'b0;
            for (int i = 0; i < 5; i++) begin
                drive((i % 2) == 0, sg, a ^ 64'h5, b ^ 64'h3);
                @(negedge clk);
                if (!ov_v || ir_v || (prod_v !== ep) || (ovf_v !== ef)) bad = 1'b1;
            end
            drive(1'b0, sg, a, b);
            chk({nm, "/hold_stable"}, 128'(bad), 128'd0);
        end
        set_ordy(1'b1);
        if (collide) drive(1'b1, sg, a, b);
        @(negedge clk);
        set_ordy(1'b0);
        drive(1'b0, sg, a, b);
        chk({nm, "/released_valid"}, 128'(ov_v), 128'd0);
        chk({nm, "/released_ready"}, 128'(ir_v), 128'd1);
        if (collide) begin
            @(negedge clk);
            chk({nm, "/no_capture_in_done"}, 128'(ir_v), 128'd1);
        end
    endtask

    initial begin
        logic [127:0] ep;
        logic         ef;
        logic         sg;
        logic [63:0]  ra, rb;
        bit           bad;

        checks   = 0;
        failures = 0;
        rst  = 1'b1;
        sel64 = 1'b0;
        iv8 = 1'b0; sg8 = 1'b0; a8 = 8'd0; b8 = 8'd0; or8 = 1'b0;
        iv64 = 1'b0; sg64 = 1'b0; a64 = 64'd0; b64 = 64'd0; or64 = 1'b0;

        vt[0] = '{1'b1, 8'hFD, 8'h05, 16'hFFF1, 1'b0};
        vt[1] = '{1'b1, 8'h80, 8'h80, 16'h4000, 1'b1};
        vt[2] = '{1'b1, 8'hFF, 8'h01, 16'hFFFF, 1'b0};
        vt[3] = '{1'b0, 8'hFF, 8'hFF, 16'hFE01, 1'b1};
        vt[4] = '{1'b0, 8'h0F, 8'h10, 16'h00F0, 1'b0};
        vt[5] = '{1'b1, 8'h00, 8'hFF, 16'h0000, 1'b0};
        vt[6] = '{1'b1, 8'h7F, 8'h7F, 16'h3F01, 1'b1};
        vt[7] = '{1'b1, 8'hF8, 8'h10, 16'hFF80, 1'b0};
        vt[8] = '{1'b1, 8'hF8, 8'h11, 16'hFF78, 1'b1};
        vt[9] = '{1'b0, 8'h10, 8'h10, 16'h0100, 1'b1};

        // Reset state, both widths, during and after reset.
        repeat (2) @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            sel64 = (s == 1);
            #0;
            chk("reset/in_ready", 128'(ir_v), 128'd1);
            chk("reset/out_valid", 128'(ov_v), 128'd0);
            chk("reset/prod", prod_v, 128'd0);
            chk("reset/ovf", 128'(ovf_v), 128'd0);
        end
        rst = 1'b0;
        sel64 = 1'b0;
        @(negedge clk);
        chk("post_reset/in_ready", 128'(ir_v), 128'd1);

        // Directed 8-bit vector table.
        for (int i = 0; i < 10; i++) begin
            run_op($sformatf("vec%0d", i), vt[i].sg, {56'd0, vt[i].a}, {56'd0, vt[i].b},
                   {112'd0, vt[i].p}, vt[i].f, (i == 0), (i == 1));
        end

        // Asynchronous reset during iteration 3 of CALC.
        @(negedge clk);
        drive(1'b1, 1'b1, 64'h55, 64'h33);
        @(negedge clk);
        drive(1'b0, 1'b1, 64'h55, 64'h33);
        repeat (3) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("midcalc_rst/in_ready", 128'(ir_v), 128'd1);
        chk("midcalc_rst/out_valid", 128'(ov_v), 128'd0);
        chk("midcalc_rst/prod", prod_v, 128'd0);
        chk("midcalc_rst/ovf", 128'(ovf_v), 128'd0);
        @(negedge clk);
        rst = 1'b0;
        bad = 1'b0;
        repeat (15) begin
            @(negedge clk);
            if (ov_v || !ir_v) bad = 1'b1;
        end
        chk("midcalc_rst/no_pulse", 128'(bad), 128'd0);
        run_op("after_rst_7x6", 1'b1, 64'd7, 64'd6, 128'h2A, 1'b0, 1'b0, 1'b0);

        // Random 8-bit operands against the model.
        for (int i = 0; i < 12; i++) begin
            sg = 1'($urandom_range(0, 1));
            ra = 64'($urandom_range(0, 255));
            rb = 64'($urandom_range(0, 255));
            model(8, sg, ra, rb, ep, ef);
            run_op($sformatf("rnd8_%0d", i), sg, ra, rb, ep, ef, 1'b0, 1'b0);
        end

        // 64-bit: boundaries then random operands.
        sel64 = 1'b1;
        run_op("w64_zero_x_m1", 1'b1, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 128'd0, 1'b0, 1'b0, 1'b0);
        run_op("w64_minneg_sq", 1'b1, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000,
               128'h4000_0000_0000_0000_0000_0000_0000_0000, 1'b1, 1'b0, 1'b0);
        run_op("w64_umax_sq", 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
               128'hFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 15; i++) begin
            sg = 1'($urandom_range(0, 1));
            ra = {$urandom, $urandom};
            rb = {$urandom, $urandom};
            if (i == 3) rb = 64'd3;
            if (i == 4) ra = 64'hFFFF_FFFF_FFFF_FFFE;
            model(64, sg, ra, rb, ep, ef);
            run_op($sformatf("rnd64_%0d", i), sg, ra, rb, ep, ef, 1'b0, 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
